arm_banked_regfile: RTL and testbench

- Responder side of the ALU/core register-access interface: holds r0–r15 with ARM7 mode banking, CPSR and per-mode SPSRs.
- Serves registered reads, same-cycle-bypassed writes, CPSR/mode reads, CPSR writes, SPSR restore, and an exception-entry sequence.
- Sits below the ALU and the exception/control unit; it is the single architectural state store of the core.

---
 rtl/arm_banked_regfile.sv | 102 ++++++++++
 tb/tb_arm_banked_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/arm_banked_regfile.sv
// arm_banked_regfile: ARM7 register file with mode banking, CPSR, SPSRs and exception entry.
// Physical storage is one flat array: user r0-r15, FIQ r8-r12, then r13 and r14 for the five privileged modes.
module arm_banked_regfile #(
    parameter logic [31:0] RESET_CPSR = 32'h000000D3,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic [3:0]  write_reg,
    input  logic [31:0] write_value,
    input  logic        write_restore_from_SPSR,
    input  logic        read_en,
    input  logic [3:0]  read_reg,
    output logic [31:0] read_value,
    input  logic        cpsr_read_en,
    output logic [31:0] cpsr_read_value,
    input  logic        cpsr_write_en,
    input  logic [31:0] cpsr_write_value,
    input  logic        mode_read_en,
    output logic [31:0] mode_read_value,
    input  logic        spsr_read_en,
    output logic [31:0] spsr_read_value,
    input  logic        exc_en,
    input  logic [4:0]  exc_mode,
    input  logic [31:0] exc_return,
    output logic        busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ENTER = 1'b1;
    localparam logic [2:0] NONE  = 3'd7;

    logic [31:0] regs [31];
    logic [31:0] spsr [5];
    logic [31:0] cpsr, cpsr_nxt, ret_q, spsr_sel;
    logic [4:0]  emode_q, wp, rp;
    logic [2:0]  cb, nb, eb;
    logic [0:0]  state;
    logic        wr;

    // Bank index: FIQ 0, IRQ 1, SVC 2, ABT 3, UND 4; NONE for USR/SYS/illegal codes.
    function automatic logic [2:0] bank(input logic [4:0] m);
        return m == 5'b10001 ? 3'd0 : m == 5'b10010 ? 3'd1 : m == 5'b10011 ? 3'd2 :
               m == 5'b10111 ? 3'd3 : m == 5'b11011 ? 3'd4 : NONE;
    endfunction

    function automatic logic [4:0] phys(input logic [4:0] m, input logic [3:0] r);
        logic [2:0] b;
        b = bank(m);
        return (b == 3'd0 && r >= 4'd8 && r <= 4'd12) ? 5'd16 + 5'(r[2:0]) :
               (b != NONE && r == 4'd13) ? 5'd21 + 5'(b) :
               (b != NONE && r == 4'd14) ? 5'd26 + 5'(b) : 5'(r);
    endfunction

    always_comb begin
        cb       = bank(cpsr[4:0]);
        eb       = bank(emode_q);
        wr       = write_en && state == IDLE;
        wp       = phys(cpsr[4:0], write_reg);
        rp       = phys(cpsr[4:0], read_reg);
        cpsr_nxt = state == ENTER ? {cpsr[31:8], 1'b1, (eb == 3'd0) | cpsr[6], cpsr[5], emode_q} :
                   (wr && write_restore_from_SPSR && cb != NONE) ? spsr[cb] :
                   cpsr_write_en ? cpsr_write_value : cpsr;
        nb       = bank(cpsr_nxt[4:0]);
        spsr_sel = nb == NONE ? cpsr_nxt : (state == ENTER && nb == eb) ? cpsr : spsr[nb];
    end

    assign busy = state == ENTER;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 31; i++) regs[i] <= (i == 15) ? RESET_PC : 32'h0;
            for (int i = 0; i < 5; i++) spsr[i] <= 32'h0;
            cpsr            <= RESET_CPSR;
            read_value      <= 32'h0;
            cpsr_read_value <= 32'h0;
            mode_read_value <= 32'h0;
            spsr_read_value <= 32'h0;
            state           <= IDLE;
            emode_q         <= 5'h0;
            ret_q           <= 32'h0;
        end else begin
            if (wr) regs[wp] <= write_value;
            if (state == ENTER) begin
                spsr[eb]                <= cpsr;
                regs[5'd26 + 5'(eb)]    <= ret_q;
            end
            cpsr <= cpsr_nxt;
            if (read_en) read_value <= (wr && wp == rp) ? write_value : regs[rp];
            if (cpsr_read_en) cpsr_read_value <= cpsr_nxt;
            if (mode_read_en) mode_read_value <= {27'b0, cpsr_nxt[4:0]};
            if (spsr_read_en) spsr_read_value <= spsr_sel;
            if (state == IDLE && exc_en && bank(exc_mode) != NONE) begin
                state   <= ENTER;
                emode_q <= exc_mode;
                ret_q   <= exc_return;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_arm_banked_regfile.sv
// tb_arm_banked_regfile: directed checks of banking, bypass, CPSR priority and exception entry.
module tb_arm_banked_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_en, write_restore_from_SPSR, read_en, cpsr_read_en, cpsr_write_en;
    logic        mode_read_en, spsr_read_en, exc_en, busy;
    logic [3:0]  write_reg, read_reg;
    logic [4:0]  exc_mode;
    logic [31:0] write_value, read_value, cpsr_read_value, cpsr_write_value;
    logic [31:0] mode_read_value, spsr_read_value, exc_return;
    int          n_checks = 0;
    int          n_fail = 0;

    arm_banked_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
        .write_restore_from_SPSR(write_restore_from_SPSR),
        .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
        .cpsr_read_en(cpsr_read_en), .cpsr_read_value(cpsr_read_value),
        .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
        .mode_read_en(mode_read_en), .mode_read_value(mode_read_value),
        .spsr_read_en(spsr_read_en), .spsr_read_value(spsr_read_value),
        .exc_en(exc_en), .exc_mode(exc_mode), .exc_return(exc_return), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        write_en = 0; write_reg = 0; write_value = 0; write_restore_from_SPSR = 0;
        read_en = 0; read_reg = 0; cpsr_read_en = 0; cpsr_write_en = 0; cpsr_write_value = 0;
        mode_read_en = 0; spsr_read_en = 0; exc_en = 0; exc_mode = 0; exc_return = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic wreg(input logic [3:0] r, input logic [31:0] v);
        write_en = 1; write_reg = r; write_value = v;
        step();
    endtask

    task automatic set_cpsr(input logic [31:0] v);
        cpsr_write_en = 1; cpsr_write_value = v;
        step();
    endtask

    task automatic rreg(input string tag, input logic [3:0] r, input logic [31:0] exp);
        read_en = 1; read_reg = r;
        step();
        chk(tag, read_value, exp);
    endtask

    task automatic rstat(input string tag, input logic [31:0] c, input logic [31:0] m, input logic [31:0] s);
        cpsr_read_en = 1; mode_read_en = 1; spsr_read_en = 1;
        step();
        chk({tag, "_cpsr"}, cpsr_read_value, c);
        chk({tag, "_mode"}, mode_read_value, m);
        chk({tag, "_spsr"}, spsr_read_value, s);
    endtask

    initial begin
        clr();
        rst_n = 0;
        step();
        step();
        chk("rst_read", read_value, 0);
        chk("rst_cpsr_port", cpsr_read_value, 0);
        chk("rst_mode_port", mode_read_value, 0);
        chk("rst_spsr_port", spsr_read_value, 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1;
        rreg("reset_r15", 4'd15, 32'h0);
        rstat("reset", 32'h000000D3, 32'h13, 32'h0);
        // SVC / IRQ r13 banking
        wreg(4'd13, 32'hAAAA);
        set_cpsr(32'h12);
        wreg(4'd13, 32'hBBBB);
        set_cpsr(32'h13);
        rreg("svc_r13", 4'd13, 32'hAAAA);
        set_cpsr(32'h12);
        rreg("irq_r13", 4'd13, 32'hBBBB);
        set_cpsr(32'h10);
        rreg("usr_r13", 4'd13, 32'h0);
        // USR write/read and same-cycle bypass
        wreg(4'd1, 32'd5);
        rreg("usr_r1", 4'd1, 32'd5);
        write_en = 1; write_reg = 4'd2; write_value = 32'd7;
        rreg("bypass_r2", 4'd2, 32'd7);
        read_en = 1; read_reg = 4'd2;
        step();
        chk("read_hold_src", read_value, 32'd7);
        step();
        chk("read_hold", read_value, 32'd7);
        // FIQ banking of r8, sharing of r7
        wreg(4'd8, 32'h22);
        wreg(4'd7, 32'h77);
        set_cpsr(32'h11);
        wreg(4'd8, 32'h11);
        rreg("fiq_r8", 4'd8, 32'h11);
        rreg("fiq_r7", 4'd7, 32'h77);
        set_cpsr(32'h10);
        rreg("usr_r8", 4'd8, 32'h22);
        // CPSR write bypass to read ports
        cpsr_write_en = 1; cpsr_write_value = 32'h600000D0;
        rstat("cpsr_bypass", 32'h600000D0, 32'h10, 32'h600000D0);
        // Exception entry to FIQ
        exc_en = 1; exc_mode = 5'b10001; exc_return = 32'h1004;
        step();
        chk("busy_enter", 32'(busy), 1);
        exc_en = 1; exc_mode = 5'b10010; exc_return = 32'h2008;
        write_en = 1; write_reg = 4'd3; write_value = 32'hDEAD;
        step();
        chk("busy_clear", 32'(busy), 0);
        rstat("after_exc", 32'h600000D1, 32'h11, 32'h600000D0);
        chk("busy_ignored", 32'(busy), 0);
        rreg("r14_fiq", 4'd14, 32'h1004);
        rreg("write_in_enter", 4'd3, 32'h0);
        // Restore from SPSR in FIQ, then ignored in USR
        write_en = 1; write_reg = 4'd15; write_value = 32'h1000; write_restore_from_SPSR = 1;
        cpsr_read_en = 1;
        step();
        chk("restore_fiq", cpsr_read_value, 32'h600000D0);
        rreg("r15_after", 4'd15, 32'h1000);
        write_en = 1; write_reg = 4'd15; write_value = 32'h2000; write_restore_from_SPSR = 1;
        cpsr_write_en = 1; cpsr_write_value = 32'h600000D3;
        cpsr_read_en = 1;
        step();
        chk("restore_usr", cpsr_read_value, 32'h600000D3);
        // Reset during exception entry
        exc_en = 1; exc_mode = 5'b11011; exc_return = 32'h3000;
        step();
        chk("busy_und", 32'(busy), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_read", read_value, 0);
        chk("mid_rst_cpsr", cpsr_read_value, 0);
        step();
        rst_n = 1;
        rreg("mid_rst_r15", 4'd15, 32'h0);
        rstat("mid_rst", 32'h000000D3, 32'h13, 32'h0);
        set_cpsr(32'h1B);
        rreg("und_r14", 4'd14, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
